// File: rtl/axi_pattern_test_master.sv
// axi_pattern_test_master: meta-AXI4 write/read-back pattern self-test master; define AXI_TEST_ERR_LOG_EN to add first-mismatch log ports
module axi_pattern_test_master #(
  parameter int A_WIDTH = 26,
  parameter int A_WIDTH_TEST = 12,
  parameter int D_WIDTH = 16,
  parameter int D_LEVEL = 1,
  parameter logic [7:0] WBURST_LEN = 8'd15,
  parameter logic [7:0] RBURST_LEN = 8'd15,
  parameter int PASSES = 0
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         pattern_sel,
  output logic               busy,
  output logic [15:0]        pass_cnt,
  output logic               error,
  output logic [15:0]        error_cnt,
  output logic               awvalid,
  input  logic               awready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [7:0]         awlen,
  output logic               wvalid,
  input  logic               wready,
  output logic               wlast,
  output logic [D_WIDTH-1:0] wdata,
  input  logic               bvalid,
  output logic               bready,
  output logic               arvalid,
  input  logic               arready,
  output logic [A_WIDTH-1:0] araddr,
  output logic [7:0]         arlen,
  input  logic               rvalid,
  output logic               rready,
  input  logic               rlast,
  input  logic [D_WIDTH-1:0] rdata
`ifdef AXI_TEST_ERR_LOG_EN
  ,
  output logic [A_WIDTH-1:0] err_addr,
  output logic [D_WIDTH-1:0] err_exp,
  output logic [D_WIDTH-1:0] err_got
`endif
);
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, PASS_END} state_t;
  localparam int REP = (D_WIDTH + 15) / 16;
  localparam logic [A_WIDTH_TEST-1:0] WSTEP = A_WIDTH_TEST'((int'(WBURST_LEN) + 1) << D_LEVEL);
  localparam logic [A_WIDTH_TEST-1:0] RSTEP = A_WIDTH_TEST'((int'(RBURST_LEN) + 1) << D_LEVEL);
  state_t state, nxt;
  logic [A_WIDTH_TEST-1:0] base, beat_off, nxt_base;
  logic [7:0] beat;
  logic [15:0] seed;
  logic [16*REP-1:0] seed_rep;
  logic [1:0] pat;
  logic [A_WIDTH-1:0] beat_addr;
  logic [D_WIDTH-1:0] exp_data;
  logic stop_lat, last_burst, rd_hit, mismatch, done, accept;
  assign accept = state == IDLE && start;
  assign nxt_base = base + (state == B ? WSTEP : RSTEP);
  assign last_burst = nxt_base == '0;
  assign beat_off = base + (A_WIDTH_TEST'(beat) << D_LEVEL);
  assign beat_addr = A_WIDTH'(beat_off);
  assign seed_rep = {REP{seed}};
  // Pattern is a pure function of the beat address, so read-back needs no storage
  assign exp_data = pat == 2'd0 ? D_WIDTH'(beat_addr) :
                    pat == 2'd1 ? D_WIDTH'(~beat_addr) :
                    pat == 2'd2 ? D_WIDTH'(beat_addr) ^ seed_rep[D_WIDTH-1:0] :
                    D_WIDTH'(1) << beat_addr[D_LEVEL +: $clog2(D_WIDTH)];
  assign rd_hit = state == R && rvalid;
  assign mismatch = rd_hit && rdata != exp_data;
  assign done = stop_lat || stop || (PASSES != 0 && int'(pass_cnt) + 1 == PASSES);
  assign busy = state != IDLE;
  assign awvalid = state == AW;
  assign wvalid = state == W;
  assign wlast = state == W && beat == WBURST_LEN;
  assign bready = state == B;
  assign arvalid = state == AR;
  assign rready = state == R;
  assign awaddr = A_WIDTH'(base);
  assign araddr = A_WIDTH'(base);
  assign wdata = exp_data;
  assign awlen = WBURST_LEN;
  assign arlen = RBURST_LEN;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = start ? AW : IDLE;
      AW:       nxt = awready ? W : AW;
      W:        nxt = wready && wlast ? B : W;
      B:        nxt = bvalid ? (last_burst ? AR : AW) : B;
      AR:       nxt = arready ? R : AR;
      R:        nxt = rvalid && rlast ? (last_burst ? PASS_END : AR) : R;
      PASS_END: nxt = done ? IDLE : AW;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge aclk)
    if (areset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge aclk)
    if (areset) begin
      base <= '0;
      beat <= '0;
      seed <= 16'h0001;
      pat <= '0;
      stop_lat <= 1'b0;
      pass_cnt <= '0;
      error_cnt <= '0;
      error <= 1'b0;
    end else begin
      error <= mismatch;
      stop_lat <= state == IDLE ? start & stop : stop_lat | stop;
      if (accept) begin
        base <= '0;
        pat <= pattern_sel;
        pass_cnt <= '0;
        error_cnt <= '0;
      end
      if ((state == AW && awready) || (state == AR && arready)) beat <= '0;
      if ((state == W && wready) || rd_hit) beat <= beat + 8'd1;
      if ((state == B && bvalid) || (rd_hit && rlast)) base <= nxt_base;
      if (mismatch && error_cnt != 16'hFFFF) error_cnt <= error_cnt + 16'd1;
      if (state == PASS_END) begin
        pass_cnt <= pass_cnt + 16'd1;
        seed <= {seed[14:0], seed[15] ^ seed[13]};
      end
    end
`ifdef AXI_TEST_ERR_LOG_EN
  logic err_seen;
  always_ff @(posedge aclk)
    if (areset || accept) begin
      err_seen <= 1'b0;
      err_addr <= '0;
      err_exp <= '0;
      err_got <= '0;
    end else if (mismatch && !err_seen) begin
      err_seen <= 1'b1;
      err_addr <= beat_addr;
      err_exp <= exp_data;
      err_got <= rdata;
    end
`endif
endmodule
